sha256_msg_schedule: RTL and testbench
======================================

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

Interface
REQ-001 The block SHALL have no parameters; the round count is fixed at 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 blk_valid  input  1  a 512-bit message block is offered on blk_data.
REQ-005 blk_ready  output  1  block can be accepted this cycle.
REQ-006 blk_data  input  512  message block, big-endian words: M0 = [511:480], M15 = [31:0].
REQ-007 w_valid  output  1  w_data/w_idx/w_last carry schedule word W[t].
REQ-008 w_ready  input  1  downstream compression round consumes W[t] this cycle.
REQ-009 w_data  output  32  schedule word W[t].
REQ-010 w_idx  output  6  round index t, 0..63.
REQ-011 w_last  output  1  high when w_idx == 63 and w_valid is high.
REQ-012 busy  output  1  high while a block is being expanded (state RUN).

Function
REQ-013 The block SHALL use two states: IDLE and RUN.
REQ-014 IDLE: blk_ready = 1, w_valid = 0, busy = 0.
REQ-015 RUN: blk_ready = 0, w_valid = 1, busy = 1; no new block is accepted until the current one finishes (no overlap).
REQ-016 An accept (blk_valid && blk_ready) SHALL load a 16-word window with M0..M15 (slot 0 = M0), set t = 0 and enter RUN on the next cycle. W[0] is valid in the first RUN cycle: latency is 1 cycle.
REQ-017 w_data SHALL equal window slot 0 and w_idx SHALL equal t, both driven directly from registers.
REQ-018 On a transfer (w_valid && w_ready):
  - the window shifts down one slot (slot i takes slot i+1);
  - slot 15 takes W[t+16] = s1(slot14) + slot9 + s0(slot1) + slot0, mod 2^32, all operands taken before the shift;
  - t increments.
REQ-019 s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x); s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x). ROTRn is a 32-bit right rotate and SHRn is a logical right shift.
REQ-020 Words beyond W[63] are computed but never presented. Their values are don't-care.
REQ-021 A transfer at t == 63 SHALL return the block to IDLE on the next cycle, with blk_ready = 1 in that cycle. A new block is therefore accepted no earlier than 1 cycle after w_last is transferred.
REQ-022 While w_valid = 1 and w_ready = 0, w_data, w_idx and w_last SHALL hold stable; the window and t SHALL not change.
REQ-023 w_ready asserted in IDLE SHALL have no effect.
REQ-024 blk_valid asserted in RUN SHALL be ignored; the upstream block holds blk_data until blk_ready rises.
REQ-025 With w_ready held at 1, one block SHALL complete in exactly 64 RUN cycles. Block-to-block throughput is 65 cycles.

Reset
REQ-026 When rst = 1 at a clock edge, the block SHALL enter IDLE and clear t and all window slots to 0.
REQ-027 After reset: blk_ready = 1, w_valid = 0, w_data = 0, w_idx = 0, w_last = 0, busy = 0.
REQ-028 Reset during RUN SHALL abandon the block immediately. No further words are presented, and a block offered in the first post-reset cycle SHALL be accepted.
REQ-029 rst SHALL take priority over a simultaneous accept or transfer.

Verification
REQ-030 "abc" padded block (M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018), w_ready = 1 -> W0 = 0x61626380, W15 = 0x00000018, W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405, W19 = 0x600003C6, W63 = 0x12B1EDEB. w_last is high only at w_idx 63, and blk_ready rises 1 cycle later.
REQ-031 Backpressure: same block, w_ready low for 3 cycles at t = 5 and randomly elsewhere -> w_data = W5 and w_idx = 5 stable throughout each stall, and the full W0..W63 sequence matches REQ-030 and a reference model.
REQ-032 Back-to-back: two blocks offered continuously with w_ready = 1 -> the second block is accepted in the cycle after W63 of the first is transferred, and 128 words are delivered in order.
REQ-033 Ignore-in-RUN: blk_valid pulsed with different data at t = 10 -> no effect on the current words, blk_ready stays 0 until completion.
REQ-034 Mid-operation reset at t = 30 -> the next cycle shows w_valid = 0, blk_ready = 1 and w_data = 0. A fresh "abc" block then reproduces REQ-030 exactly.
REQ-035 Random blocks (≥1000) with random w_ready -> all 64 words match the software model, with no lost or duplicated index.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule expander.
// Accepts one 512-bit block and streams W[0..63] over a valid/ready port,
// using a 16-word sliding window that computes W[t+16] on every transfer.
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         busy
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  t_q, t_d;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // W[t+16] from the pre-shift window (slot k holds W[t+k])
  assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  // Next-state: load on accept, shift and extend on transfer, hold otherwise
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        if (blk_valid) begin
          for (int i = 0; i < 16; i++) begin
            win_d[i] = blk_data[511 - 32*i -: 32];
          end
          t_d     = 6'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (w_ready) begin
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[15] = w_new;
          t_d       = t_q + 6'd1;
          if (t_q == 6'd63) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    blk_ready = (state_q == StIdle);
    w_valid   = (state_q == StRun);
    busy      = (state_q == StRun);
    w_data    = win_q[0];
    w_idx     = t_q;
    w_last    = (state_q == StRun) && (t_q == 6'd63);
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: scoreboard of expected words
// plus a table of known "abc" schedule values and targeted corner sequences.
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         busy;

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_idx     (w_idx),
    .w_last    (w_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [511:0] blk;
    int           idx;
    logic [31:0]  exp;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] got [64];
  vec_t        vecs [7];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          dut_xfers = 0;
  int          run_cycles = 0;
  int          last_xfer_cyc = 0;
  bit          exp_busy = 1'b0;
  bit          acc_flag;
  logic [511:0] abc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule in the textbook W[t-2], W[t-7], W[t-15], W[t-16] form
  function automatic void push_block(input logic [511:0] b);
    logic [31:0] w [64];
    exp_t        e;
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = ms1(w[t-2]) + w[t-7] + ms0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.idx  = t[5:0];
      e.data = w[t];
      sb.push_back(e);
    end
  endfunction

  // One clock: check outputs against the model, advance the model, cross the edge
  task automatic tick();
    exp_t e;
    bit   exp_last;
    acc_flag = 1'b0;
    exp_last = exp_busy && (sb.size() > 0) && (sb[0].idx == 6'd63);
    chk("busy", busy, exp_busy);
    chk("blk_ready", blk_ready, !exp_busy);
    chk("w_valid", w_valid, exp_busy);
    chk("w_last", w_last, exp_last);
    if (busy) run_cycles++;
    if (w_valid && w_ready) begin
      dut_xfers++;
      got[w_idx] = w_data;
    end
    if (rst) begin
      sb.delete();
      exp_busy = 1'b0;
    end else if (exp_busy) begin
      if (w_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got transfer expected none (cycle %0d)", cyc);
          exp_busy = 1'b0;
        end else begin
          e = sb.pop_front();
          chk("w_idx", w_idx, e.idx);
          chk("w_data", w_data, e.data);
          last_xfer_cyc = cyc;
          if (e.idx == 6'd63) exp_busy = 1'b0;
        end
      end
    end else if (blk_valid) begin
      push_block(blk_data);
      exp_busy = 1'b1;
      acc_flag = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Offer a block until accepted; returns the number of ticks it took
  task automatic offer(input logic [511:0] b, output int n);
    blk_data  = b;
    blk_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_flag && n < 100);
    if (!acc_flag) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end
    blk_valid = 1'b0;
  endtask

  // Run the current block to completion; mode 0 = w_ready held high, 1 = random
  task automatic drain(input int mode);
    int n = 0;
    while (exp_busy && n < 2000) begin
      w_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 7) != 0);
      tick();
      n++;
    end
    if (exp_busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got busy expected idle after 2000 cycles");
    end
    w_ready = 1'b0;
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = $urandom();
    return b;
  endfunction

  initial begin
    int          n;
    int          stall_n;
    logic [31:0] stall_word;
    logic [511:0] b;

    abc = {32'h61626380, 448'h0, 32'h00000018};
    vecs[0] = '{abc, 0,  32'h61626380};
    vecs[1] = '{abc, 15, 32'h00000018};
    vecs[2] = '{abc, 16, 32'h61626380};
    vecs[3] = '{abc, 17, 32'h000F0000};
    vecs[4] = '{abc, 18, 32'h7DA86405};
    vecs[5] = '{abc, 19, 32'h600003C6};
    vecs[6] = '{abc, 63, 32'h12B1EDEB};

    rst = 1'b1; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_blk_ready", blk_ready, 1'b1);
    chk("rst_w_valid", w_valid, 1'b0);
    chk("rst_w_data", w_data, 32'h0);
    chk("rst_w_idx", w_idx, 6'd0);
    chk("rst_w_last", w_last, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // w_ready in IDLE has no effect
    w_ready = 1'b1;
    tick();
    chk("idle_ready_w_idx", w_idx, 6'd0);
    w_ready = 1'b0;

    // "abc" at full rate: latency, 64 RUN cycles, table of known words
    offer(abc, n);
    chk("lat_w_valid", w_valid, 1'b1);
    chk("lat_w_idx", w_idx, 6'd0);
    run_cycles = 0;
    drain(0);
    chk("run_cycles", run_cycles, 64);
    chk("ready_after_last", cyc, last_xfer_cyc + 1);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("abc_W%0d", vecs[i].idx), got[vecs[i].idx], vecs[i].exp);
    end

    // Backpressure: 3-cycle stall at t = 5, random stalls elsewhere
    offer(abc, n);
    stall_n = 0;
    stall_word = 32'h0;
    n = 0;
    while (exp_busy && n < 2000) begin
      if (w_idx == 6'd5 && w_valid && stall_n < 3) begin
        if (stall_n == 0) stall_word = w_data;
        chk("stall_w_data", w_data, stall_word);
        chk("stall_w_last", w_last, 1'b0);
        w_ready = 1'b0;
        stall_n++;
      end else begin
        w_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
      n++;
    end
    w_ready = 1'b0;
    chk("stall_cycles", stall_n, 3);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("bp_W%0d", vecs[i].idx), got[vecs[i].idx], vecs[i].exp);
    end

    // Back-to-back: blk_valid held continuously across two blocks
    dut_xfers = 0;
    blk_data  = rand_blk();
    blk_valid = 1'b1;
    w_ready   = 1'b1;
    n = 0;
    while (!acc_flag && n < 10) begin tick(); n++; end
    blk_data = rand_blk();
    n = 0;
    do begin tick(); n++; end while (!acc_flag && n < 200);
    chk("b2b_second_accept_cyc", cyc - 1, last_xfer_cyc + 1);
    blk_valid = 1'b0;
    drain(0);
    chk("b2b_words", dut_xfers, 128);

    // blk_valid with different data during RUN is ignored
    offer(abc, n);
    n = 0;
    w_ready = 1'b1;
    while (exp_busy && n < 200) begin
      if (sb.size() > 0 && sb[0].idx == 6'd10) begin
        blk_valid = 1'b1;
        blk_data  = rand_blk();
        chk("ign_blk_ready", blk_ready, 1'b0);
      end else begin
        blk_valid = 1'b0;
      end
      tick();
      n++;
    end
    blk_valid = 1'b0;
    w_ready = 1'b0;
    chk("ign_W63", got[63], 32'h12B1EDEB);

    // Mid-operation reset at t = 30, then a fresh block in the first cycle
    offer(abc, n);
    w_ready = 1'b1;
    n = 0;
    while (exp_busy && sb[0].idx != 6'd30 && n < 200) begin tick(); n++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    w_ready = 1'b0;
    chk("mrst_w_valid", w_valid, 1'b0);
    chk("mrst_blk_ready", blk_ready, 1'b1);
    chk("mrst_w_data", w_data, 32'h0);
    chk("mrst_w_idx", w_idx, 6'd0);
    offer(abc, n);
    chk("mrst_accept_first_cycle", n, 1);
    drain(0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("mrst_W%0d", vecs[i].idx), got[vecs[i].idx], vecs[i].exp);
    end

    // Random blocks, alternating full-rate and random backpressure
    for (int k = 0; k < 1000; k++) begin
      b = rand_blk();
      offer(b, n);
      drain(k % 2);
    end

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
